cpu_bus_responder: RTL

Target-side end of the CPU system bus. Watches the initiator's bus strobe, address, write-enable and data, and decodes a 16-word register window at BASE_ADDR. It inserts a programmable number of wait states and completes each access with a four-phase data-ready handshake. Several instances may share one bus; read data is zero when an instance is not selected, so instance outputs can be ORed together.

---
 rtl/cpu_bus_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Target-side responder for the CPU system bus. Decodes a 16-word register
//   window at BASE_ADDR, inserts WAIT_STATES idle cycles, then completes the
//   access with a four-phase ready handshake. Read data is forced to zero when
//   this instance is not presenting a read, so several instances can be
//   wire-ORed on a shared bus.
//
// Ports
//   i_cpu_clk         system clock (rising edge)
//   i_rst             asynchronous active-high reset
//   i_bus_clk         initiator request strobe (level)
//   i_bus_we          1 = write, 0 = read
//   i_bus_addr        word address
//   i_bus_data        write data
//   o_bus_data        read data (zero unless in ACK for a read)
//   o_bus_data_ready  access-complete handshake
//   o_busy            high in WAIT or ACK
//   o_ctrl            live value of register 2
module cpu_bus_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_F000,
  parameter int                WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = 'h6583_2001
) (
  input  logic              i_cpu_clk,
  input  logic              i_rst,
  input  logic              i_bus_clk,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_data,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_data_ready,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_ctrl
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  // Slot 0 is never written; its read value comes from ID_VALUE.
  logic [15:0][DATA_W-1:0] regs_q, regs_d;

  logic                    sel;
  logic [DATA_W-1:0]       rd_val;

  assign sel = i_bus_clk && (i_bus_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);

  always_comb begin
    rd_val = regs_q[idx_q];
    if (idx_q == 4'd0) rd_val = ID_VALUE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    // Tick counter runs every cycle; a write to R1 below overrides it.
    regs_d[1] = regs_q[1] + DATA_W'(1);

    case (state_q)
      S_IDLE: begin
        if (sel) begin
          idx_d   = i_bus_addr[3:0];
          we_d    = i_bus_we;
          wdata_d = i_bus_data;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (!i_bus_clk) begin
          // Initiator abort: drop the access without side effects.
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (we_q) begin
            if (idx_q != 4'd0) regs_d[idx_q] = wdata_q;
          end else begin
            // R1 returns its pre-increment value here.
            rdata_d = rd_val;
          end
          ready_d = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!i_bus_clk) begin
          ready_d = 1'b0;
          rdata_d = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        rdata_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  assign o_bus_data       = rdata_q;
  assign o_bus_data_ready = ready_q;
  assign o_busy           = busy_q;
  assign o_ctrl           = regs_q[2];

endmodule
